// File: rtl/uart_rx_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Word type, receiver state encoding and default bit period.
package Definitions_Package;

    localparam int UART_BAUD_DIV = 5208;
    localparam int UART_WORD_LEN = 8;

    typedef logic [UART_WORD_LEN-1:0] word_lenght_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period timer for the UART receiver.
// Fires tick at half or full bit period, then wraps to 0.
module uart_rx_baud_cnt
    import Definitions_Package::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_T = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_T = CW'(BAUD_DIV / 2 - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == (half ? HALF_T : FULL_T));

    // Count cycles within the current bit; held at 0 when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, start validation, mid-bit sampling,
// and a valid/clear handshake with parity, frame and overrun flags.
module uart_rx
    import Definitions_Package::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX,
    input  logic         RX_clr,
    output word_lenght_t Data_Received,
    output logic         RX_valid,
    output logic         Parity_err,
    output logic         Frame_err,
    output logic         Overrun
);

    localparam int W = UART_WORD_LEN;
    localparam logic [2:0] LAST_BIT = 3'(W - 1);

    uart_rx_state_t state;
    uart_rx_state_t state_n;

    logic         rx_meta;
    logic         rx_s;
    logic [1:0]   sync_vld;
    logic         armed;
    logic         tick;
    logic [2:0]   bit_cnt;
    word_lenght_t shreg;
    logic         par_err;
    logic         cmt;
    logic         cmt_ferr;
    logic         shift_en;
    logic         par_smp;
    logic         stop_smp;

    uart_rx_baud_cnt #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .clr (state == IDLE),
        .half(state == START),
        .tick(tick)
    );

    // Two-flop synchronizer; sync_vld marks when rx_s holds a real sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= RX;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // A start edge is accepted only after the line has been seen idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (stop_smp && !rx_s) begin
            armed <= 1'b0;
        end else if (rx_s && sync_vld[1]) begin
            armed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and per-bit sample strobes.
    always_comb begin
        state_n  = state;
        shift_en = 1'b0;
        par_smp  = 1'b0;
        stop_smp = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && !rx_s) state_n = START;
            end
            START: begin
                if (tick) state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                shift_en = tick;
                if (tick && bit_cnt == LAST_BIT) begin
                    state_n = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_smp = tick;
                if (tick) state_n = STOP;
            end
            STOP: begin
                stop_smp = tick;
                if (tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame assembly: shift data LSB first, check parity, flag commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            cmt      <= 1'b0;
            cmt_ferr <= 1'b0;
        end else begin
            cmt <= stop_smp;
            if (stop_smp) cmt_ferr <= !rx_s;
            if (state == START) begin
                bit_cnt <= '0;
                par_err <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {rx_s, shreg[W-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_smp) par_err <= (^shreg) ^ rx_s;
        end
    end

    // Consumer-facing word and flags; a commit outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Received <= '0;
            RX_valid      <= 1'b0;
            Parity_err    <= 1'b0;
            Frame_err     <= 1'b0;
            Overrun       <= 1'b0;
        end else if (cmt) begin
            if (!RX_valid || RX_clr) begin
                Data_Received <= shreg;
                Parity_err    <= par_err;
                Frame_err     <= cmt_ferr;
                RX_valid      <= 1'b1;
                if (RX_clr) Overrun <= 1'b0;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (RX_clr) begin
            RX_valid   <= 1'b0;
            Overrun    <= 1'b0;
            Parity_err <= 1'b0;
            Frame_err  <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side companion of the UART transmit path, built from the same frame format and `Definitions_Package` types. It synchronizes the asynchronous serial line, detects and validates the start bit, samples data/parity/stop at mid-bit, and presents the received word with a valid/clear handshake plus error flags. It sits between the external RX pin and the register/control logic that consumes received words.

## Interface
- `BAUD_DIV`, 5208: clock cycles per bit (50 MHz / 9600); must be >= 4 and even.
- `PARITY_EN`, 0: 1 = frame carries an even-parity bit after the data bits.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `RX` input 1: asynchronous serial line, idle high.
- `RX_clr` input 1: consumer acknowledge; clears `RX_valid`, `Overrun`, `Parity_err`, `Frame_err`.
- `Data_Received` output `word_lenght_t` (8): last accepted word, LSB received first.
- `RX_valid` output 1: word held in `Data_Received` is unread.
- `Parity_err` output 1: parity mismatch in the held frame (always 0 when `PARITY_EN`=0).
- `Frame_err` output 1: stop bit sampled low in the held frame.
- `Overrun` output 1: sticky; a frame completed while `RX_valid` was 1.

## Operation
- Frame: 1 start (0), 8 data LSB first, optional even parity, 1 stop (1).
- `RX` passes through a 2-FF synchronizer (`rx_s`), reset value 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: baud counter held at 0; `rx_s`==0 -> START.
  - START: count `BAUD_DIV/2` cycles; at terminal count sample `rx_s`: 0 -> DATA (counter reset), 1 -> IDLE (glitch rejected, no flag).
  - DATA: every `BAUD_DIV` cycles shift `rx_s` into the MSB of the shift register; after 8th sample -> PARITY if `PARITY_EN`, else STOP.
  - PARITY: sample after `BAUD_DIV` cycles; error = XOR(data bits, sample) != 0 -> STOP.
  - STOP: sample after `BAUD_DIV` cycles, then commit and go to IDLE immediately (back-to-back frames supported).
- Commit (cycle after the stop sample):
  - `RX_valid`==0 or `RX_clr`==1: load `Data_Received`, `Parity_err`, `Frame_err`; `RX_valid`<=1.
  - `RX_valid`==1 and `RX_clr`==0: keep old data/flags, set `Overrun`, drop the new frame.
- Frame error: frame still committed with `Frame_err`=1; FSM returns to IDLE and re-arms only after `rx_s` is seen high (break holds the FSM in IDLE, no spurious frames).
- `RX_clr` outside a commit cycle: clears `RX_valid`, `Overrun`, errors; `Data_Received` retains value.

## Timing
- Reset values: `Data_Received`=0, `RX_valid`=0, `Parity_err`=0, `Frame_err`=0, `Overrun`=0, FSM=IDLE, counters 0.
- Start-edge detection latency: 2 cycles (synchronizer) + 1 cycle (IDLE->START).
- `RX_valid` rises 1 cycle after the stop-bit sample, i.e. about 9.5 bit-times (10.5 with parity) after the falling start edge plus 3 cycles.
- `RX_clr` is a level; it acts in every cycle it is high. It has priority only over the stale state, never over a frame committing in the same cycle.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is lost. After deassertion, a line still low is treated as a start edge only after `rx_s` is first seen high.
- Baud counter width: $clog2(`BAUD_DIV`); wraps to 0 at `BAUD_DIV`-1.

## Structure
- `Definitions_Package`: reuse `word_lenght_t`; add `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and `UART_BAUD_DIV` default constant shared with TX.
- One sub-module: `uart_rx_baud_cnt` (enable, clear, half/full select; outputs `tick`). The bit counter, shift register, and FSM live in `uart_rx`.

## Test plan
- `BAUD_DIV`=16, `PARITY_EN`=0, send 0xA5 -> `Data_Received`=0xA5, `RX_valid`=1 one cycle after the stop sample, no flags.
- `PARITY_EN`=1, send 0x07 with parity bit 0 (wrong) -> `Data_Received`=0x07, `Parity_err`=1; same word with parity 1 -> `Parity_err`=0.
- Low glitch of 4 cycles on idle line -> FSM returns to IDLE, `RX_valid` stays 0; send 0x3C with stop bit 0, then hold line low 40 cycles -> one frame committed with `Frame_err`=1, no second frame until line is high.
- Back-to-back 0x11, 0x22 without `RX_clr` -> `Data_Received`=0x11, `Overrun`=1; pulse `RX_clr` in the exact commit cycle of the second frame -> 0x22 loaded, `Overrun`=0.
- Assert `rst` during data bit 4 of 0xFF -> all outputs 0 immediately; a following clean 0x5A is received correctly.
